// File: rtl/alarm_pkg.sv
// Shared types for the alarm sequencer: internal state enum, external 2-bit
// state encodings, and the 16-bit delay type.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_EXIT,
    ST_ARMED,
    ST_ENTRY,
    ST_ALARM
  } alarm_state_e;

  localparam logic [1:0] EXT_OFF       = 2'b00;
  localparam logic [1:0] EXT_ARMED     = 2'b01;
  localparam logic [1:0] EXT_TRIGGERED = 2'b10;
  localparam logic [1:0] EXT_ALARM_ON  = 2'b11;

  typedef logic [15:0] dly_t;

  // EXIT is reported as ARMED externally; exit_active tells them apart.
  function automatic logic [1:0] ext_enc(alarm_state_e s);
    case (s)
      ST_OFF:   return EXT_OFF;
      ST_EXIT:  return EXT_ARMED;
      ST_ARMED: return EXT_ARMED;
      ST_ENTRY: return EXT_TRIGGERED;
      ST_ALARM: return EXT_ALARM_ON;
      default:  return EXT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/alarm_dly_timer.sv
// Loadable, ena-gated 16-bit down-counter; done flags the last cycle of a delay.
module alarm_dly_timer
  import alarm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic load,
  input  dly_t load_val,
  output logic done
);

  dly_t r_cnt;

  // Saturates at zero so a long stay in one state never wraps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (ena && (r_cnt != '0)) begin
      r_cnt <= r_cnt - dly_t'(1);
    end
  end

  assign done = (r_cnt <= dly_t'(1));

endmodule

// File: rtl/alarm_seq_ctrl.sv
// Alarm sequencer: OFF -> EXIT -> ARMED -> ENTRY -> ALARM with code disarm and
// bad-code tamper. Define SIREN_TIMEOUT_EN to auto-silence ALARM back to ARMED.
module alarm_seq_ctrl
  import alarm_pkg::*;
#(
  parameter dly_t       EXIT_DLY     = 16'd8,
  parameter dly_t       ENTRY_DLY    = 16'd8,
  parameter dly_t       SIREN_DLY    = 16'd32,
  parameter logic [3:0] CODE         = 4'hA,
  parameter logic [3:0] INSTANT_MASK = 4'b0001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       arm_req,
  input  logic       code_valid,
  input  logic [3:0] code,
  input  logic [3:0] zone,
  output logic       alarm,
  output logic [1:0] state,
  output logic [1:0] next_state,
  output logic       exit_active,
  output logic       arm_fault
);

  alarm_state_e r_state;
  alarm_state_e w_next;
  logic [1:0]   r_bad;
  logic [1:0]   w_bad_next;
  logic         r_alarm;
  logic         r_fault;
  logic         w_fault;
  logic         w_code_ok;
  logic         w_code_bad;
  logic         w_instant;
  logic         w_done;
  logic         w_load;
  dly_t         w_load_val;

  assign w_code_ok  = code_valid && (code == CODE);
  assign w_code_bad = code_valid && (code != CODE);
  assign w_instant  = (zone & INSTANT_MASK) != 4'b0000;

  // Branch order below encodes event priority: good code, tamper, instant
  // zone, timer expiry, delayed zone.
  always_comb begin
    w_next     = r_state;
    w_bad_next = r_bad;
    w_fault    = 1'b0;
    if (ena) begin
      if (r_state == ST_OFF) begin
        if (arm_req) begin
          if (zone == 4'b0000) w_next = ST_EXIT;
          else                 w_fault = 1'b1;
        end
      end else if (w_code_ok) begin
        w_next = ST_OFF;
      end else begin
        if (w_code_bad && (r_bad != 2'd3)) w_bad_next = r_bad + 2'd1;
        if (w_code_bad && (r_bad >= 2'd2)) begin
          w_next = ST_ALARM;
        end else if (w_instant && ((r_state == ST_ARMED) || (r_state == ST_ENTRY))) begin
          w_next = ST_ALARM;
        end else if (w_done && (r_state == ST_EXIT)) begin
          w_next = ST_ARMED;
        end else if (w_done && (r_state == ST_ENTRY)) begin
          w_next = ST_ALARM;
`ifdef SIREN_TIMEOUT_EN
        end else if (w_done && (r_state == ST_ALARM)) begin
          w_next     = ST_ARMED;
          w_bad_next = 2'd0;
`endif
        end else if ((r_state == ST_ARMED) && (zone != 4'b0000)) begin
          w_next = ST_ENTRY;
        end
      end
      if (w_next == ST_OFF) w_bad_next = 2'd0;
    end
  end

  // Every state change reloads the timer, so OFF/ARMED entries leave no residue.
  always_comb begin
    w_load     = (w_next != r_state);
    w_load_val = '0;
    case (w_next)
      ST_EXIT:  w_load_val = EXIT_DLY;
      ST_ENTRY: w_load_val = ENTRY_DLY;
      ST_ALARM: w_load_val = SIREN_DLY;
      default:  w_load_val = '0;
    endcase
  end

  alarm_dly_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .load     (w_load),
    .load_val (w_load_val),
    .done     (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_bad   <= 2'd0;
      r_alarm <= 1'b0;
      r_fault <= 1'b0;
    end else if (ena) begin
      r_state <= w_next;
      r_bad   <= w_bad_next;
      r_alarm <= (w_next == ST_ALARM);
      r_fault <= w_fault;
    end
  end

  assign alarm       = r_alarm;
  assign arm_fault   = r_fault;
  assign state       = ext_enc(r_state);
  assign next_state  = ext_enc(w_next);
  assign exit_active = (r_state == ST_EXIT);

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Directed and randomized checks of alarm_seq_ctrl against a cycle-level
// reference model built from elapsed-cycle counts per mode.
`timescale 1ns/1ps
module tb_alarm_seq_ctrl;

  localparam logic [15:0] P_EXIT  = 16'd4;
  localparam logic [15:0] P_ENTRY = 16'd3;
  localparam logic [15:0] P_SIREN = 16'd5;
  localparam logic [3:0]  P_CODE  = 4'hA;
  localparam logic [3:0]  P_MASK  = 4'b0001;

  localparam int M_OFF   = 0;
  localparam int M_EXIT  = 1;
  localparam int M_ARMED = 2;
  localparam int M_ENTRY = 3;
  localparam int M_ALARM = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       arm_req;
  logic       code_valid;
  logic [3:0] code;
  logic [3:0] zone;
  logic       alarm;
  logic [1:0] state;
  logic [1:0] next_state;
  logic       exit_active;
  logic       arm_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int mode;
    int elapsed;
    int bad;
    bit fault;
  } mdl_t;

  mdl_t m;

  always #5 clk = ~clk;

  alarm_seq_ctrl #(
    .EXIT_DLY     (P_EXIT),
    .ENTRY_DLY    (P_ENTRY),
    .SIREN_DLY    (P_SIREN),
    .CODE         (P_CODE),
    .INSTANT_MASK (P_MASK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .arm_req     (arm_req),
    .code_valid  (code_valid),
    .code        (code),
    .zone        (zone),
    .alarm       (alarm),
    .state       (state),
    .next_state  (next_state),
    .exit_active (exit_active),
    .arm_fault   (arm_fault)
  );

  function automatic logic [1:0] ext_of(int mode);
    case (mode)
      M_OFF:   return 2'b00;
      M_EXIT:  return 2'b01;
      M_ARMED: return 2'b01;
      M_ENTRY: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int dly_of(int mode);
    if (mode == M_EXIT)  return int'(P_EXIT);
    if (mode == M_ENTRY) return int'(P_ENTRY);
    return int'(P_SIREN);
  endfunction

  // One enabled cycle of the alarm rules; a held cycle changes nothing.
  function automatic mdl_t mdl_step(mdl_t cur, bit e, bit arm, bit cv,
                                    logic [3:0] c, logic [3:0] z);
    mdl_t n;
    int   target;
    bit   timed;
    bit   tamper;
    n = cur;
    if (!e) return n;
    n.fault = 1'b0;
    target  = cur.mode;
    timed   = (cur.mode == M_EXIT) || (cur.mode == M_ENTRY);
`ifdef SIREN_TIMEOUT_EN
    timed   = timed || (cur.mode == M_ALARM);
`endif
    if (cur.mode == M_OFF) begin
      if (arm) begin
        if (z == 4'h0) target = M_EXIT;
        else           n.fault = 1'b1;
      end
    end else if (cv && (c == P_CODE)) begin
      target = M_OFF;
    end else begin
      tamper = 1'b0;
      if (cv) begin
        tamper = (cur.bad + 1 >= 3);
        n.bad  = (cur.bad + 1 > 3) ? 3 : cur.bad + 1;
      end
      if (tamper) begin
        target = M_ALARM;
      end else if (((z & P_MASK) != 4'h0) && (cur.mode == M_ARMED || cur.mode == M_ENTRY)) begin
        target = M_ALARM;
      end else if (timed && (cur.elapsed + 1 >= dly_of(cur.mode))) begin
        if (cur.mode == M_EXIT)       target = M_ARMED;
        else if (cur.mode == M_ENTRY) target = M_ALARM;
        else begin
          target = M_ARMED;
          n.bad  = 0;
        end
      end else if ((cur.mode == M_ARMED) && (z != 4'h0)) begin
        target = M_ENTRY;
      end
    end
    if (target == M_OFF) n.bad = 0;
    n.elapsed = (target != cur.mode) ? 0 : cur.elapsed + 1;
    n.mode    = target;
    return n;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare all outputs to the model, then advance it.
  task automatic step(input bit e, input bit arm, input bit cv,
                      input logic [3:0] c, input logic [3:0] z);
    mdl_t nx;
    @(negedge clk);
    ena        = e;
    arm_req    = arm;
    code_valid = cv;
    code       = c;
    zone       = z;
    #1;
    nx = mdl_step(m, e, arm, cv, c, z);
    check("state",       {2'b00, state},         {2'b00, ext_of(m.mode)});
    check("alarm",       {3'b000, alarm},        {3'b000, (m.mode == M_ALARM)});
    check("exit_active", {3'b000, exit_active},  {3'b000, (m.mode == M_EXIT)});
    check("arm_fault",   {3'b000, arm_fault},    {3'b000, m.fault});
    check("next_state",  {2'b00, next_state},    {2'b00, ext_of(nx.mode)});
    @(posedge clk);
    m = nx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
  endtask

  task automatic expect_now(input string tag, input logic [1:0] st, input logic al);
    #1;
    check({tag, "_state"}, {2'b00, state}, {2'b00, st});
    check({tag, "_alarm"}, {3'b000, alarm}, {3'b000, al});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m.mode = M_OFF; m.elapsed = 0; m.bad = 0; m.fault = 1'b0;
    check("rst_state",       {2'b00, state},        4'h0);
    check("rst_alarm",       {3'b000, alarm},       4'h0);
    check("rst_exit_active", {3'b000, exit_active}, 4'h0);
    check("rst_arm_fault",   {3'b000, arm_fault},   4'h0);
    ena = 1'b0; arm_req = 1'b0; code_valid = 1'b0; code = 4'h0; zone = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit         r_e;
    bit         r_a;
    bit         r_cv;
    logic [3:0] r_c;
    logic [3:0] r_z;
    rst_n = 1'b0;
    ena = 1'b0; arm_req = 1'b0; code_valid = 1'b0; code = 4'h0; zone = 4'h0;
    do_reset();

    // Refused arm with a zone open: one-cycle fault pulse, stays OFF.
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'b0100);
    #1;
    check("fault_pulse", {3'b000, arm_fault}, 4'h1);
    check("fault_state", {2'b00, state}, 4'h0);
    idle(2);

    // Exit delay: four EXIT cycles then ARMED.
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(3);
    #1;
    check("exit_last", {3'b000, exit_active}, 4'h1);
    idle(1);
    expect_now("armed", 2'b01, 1'b0);
    check("exit_done", {3'b000, exit_active}, 4'h0);

    // Delayed zone: three ENTRY cycles, then ALARM; good code disarms.
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'b0010);
    idle(2);
    expect_now("entry", 2'b10, 1'b0);
    idle(1);
    expect_now("entry_exp", 2'b11, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 1'b1, P_CODE, 4'h0);
    expect_now("disarm", 2'b00, 1'b0);

    // Instant zone from ARMED.
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(4);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'b0001);
    expect_now("instant", 2'b11, 1'b1);
    step(1'b1, 1'b0, 1'b1, P_CODE, 4'h0);

    // Three bad codes in ARMED trip the tamper alarm.
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(4);
    step(1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
    step(1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
    expect_now("bad2", 2'b01, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h3, 4'h0);
    expect_now("tamper", 2'b11, 1'b1);
    step(1'b1, 1'b0, 1'b1, P_CODE, 4'h0);

    // Held cycles during EXIT stretch it; zones are ignored in EXIT.
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'b0011);
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'b0011);
    step(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h3, 4'h0);
    idle(3);
    expect_now("exit_held", 2'b01, 1'b0);

    // Priority: instant over delayed, good code over instant.
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'b0011);
    expect_now("inst_prio", 2'b11, 1'b1);
    step(1'b1, 1'b0, 1'b1, P_CODE, 4'h0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(4);
    step(1'b1, 1'b0, 1'b1, 4'h5, 4'b0010);
    step(1'b1, 1'b0, 1'b1, P_CODE, 4'b0001);
    expect_now("code_prio", 2'b00, 1'b0);

    // Arm together with a code in OFF is an arm.
    step(1'b1, 1'b1, 1'b1, P_CODE, 4'h0);
    expect_now("arm_code", 2'b01, 1'b0);
    idle(4);

    // Reset mid-ENTRY aborts; re-arm runs a full exit delay.
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'b0100);
    idle(1);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
    idle(4);

`ifdef SIREN_TIMEOUT_EN
    step(1'b1, 1'b0, 1'b0, 4'h0, 4'b0001);
    idle(4);
    expect_now("siren_on", 2'b11, 1'b1);
    idle(1);
    expect_now("siren_off", 2'b01, 1'b0);
`endif

    for (int it = 0; it < 800; it++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        r_e  = ($urandom_range(0, 9) != 0);
        r_a  = ($urandom_range(0, 11) == 0);
        r_cv = ($urandom_range(0, 9) == 0);
        r_c  = ($urandom_range(0, 2) == 0) ? P_CODE : 4'($urandom_range(0, 15));
        r_z  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        step(r_e, r_a, r_cv, r_c, r_z);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
